// File: rtl/register_file_scoreboard.sv
// Parametrised 2^A x W register file: three combinational read ports, two prioritised
// write ports and a per-register busy scoreboard. REGFILE_BYPASS_EN selects write-first reads.
module register_file_scoreboard #(
  parameter int W = 32,
  parameter int A = 4
) (
  input  logic         clk,
  input  logic         reset_synchronous,
  input  logic         write_enable,
  input  logic [A-1:0] inp_write_address0,
  input  logic [W-1:0] inp_write_data,
  input  logic         write_enable1,
  input  logic [A-1:0] inp_write_address1,
  input  logic [W-1:0] inp_write_data1,
  input  logic [A-1:0] inp_read_address0,
  input  logic [A-1:0] inp_read_address1,
  input  logic [A-1:0] inp_read_address2,
  output logic [W-1:0] out_read_data0,
  output logic [W-1:0] out_read_data1,
  output logic [W-1:0] out_read_data2,
  output logic         out_busy0,
  output logic         out_busy1,
  output logic         out_busy2,
  input  logic         reserve_enable,
  input  logic [A-1:0] inp_reserve_address,
  output logic         out_reserve_conflict,
  output logic [A:0]   out_busy_count
);
  // No handshake: every enabled write or reserve is accepted on the clock edge it is
  // presented; the block never backpressures.
  localparam int DEPTH = 1 << A;

  logic [W-1:0]     regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_next;
  logic [A:0]       count_next;
  logic             write0_live;
  logic             conflict_next;
  logic [A-1:0]     read_addr [3];
  logic [W-1:0]     read_data [3];
  logic             read_busy [3];

  // Port 0 is dropped when port 1 targets the same register.
  assign write0_live = write_enable &&
                       !(write_enable1 && (inp_write_address1 == inp_write_address0));

  // A reserve overrides a same-cycle write because it names a newer producer.
  always_comb begin
    busy_next = busy;
    if (write_enable)   busy_next[inp_write_address0]  = 1'b0;
    if (write_enable1)  busy_next[inp_write_address1]  = 1'b0;
    if (reserve_enable) busy_next[inp_reserve_address] = 1'b1;
  end

  always_comb begin
    count_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_next = count_next + {{A{1'b0}}, busy_next[i]};
    end
  end

  assign conflict_next = reserve_enable && busy[inp_reserve_address] &&
                         !(write_enable  && (inp_write_address0 == inp_reserve_address)) &&
                         !(write_enable1 && (inp_write_address1 == inp_reserve_address));

  always_ff @(posedge clk) begin
    if (reset_synchronous) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy                 <= '0;
      out_reserve_conflict <= 1'b0;
      out_busy_count       <= '0;
    end else begin
      if (write0_live)   regs[inp_write_address0] <= inp_write_data;
      if (write_enable1) regs[inp_write_address1] <= inp_write_data1;
      busy                 <= busy_next;
      out_reserve_conflict <= conflict_next;
      out_busy_count       <= count_next;
    end
  end

  assign read_addr[0] = inp_read_address0;
  assign read_addr[1] = inp_read_address1;
  assign read_addr[2] = inp_read_address2;

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      read_data[p] = regs[read_addr[p]];
      read_busy[p] = busy[read_addr[p]];
`ifdef REGFILE_BYPASS_EN
      if (write_enable1 && (inp_write_address1 == read_addr[p])) begin
        read_data[p] = inp_write_data1;
        read_busy[p] = 1'b0;
      end else if (write_enable && (inp_write_address0 == read_addr[p])) begin
        read_data[p] = inp_write_data;
        read_busy[p] = 1'b0;
      end
      if (reserve_enable && (inp_reserve_address == read_addr[p])) read_busy[p] = 1'b1;
`endif
    end
  end

  assign out_read_data0 = read_data[0];
  assign out_read_data1 = read_data[1];
  assign out_read_data2 = read_data[2];
  assign out_busy0      = read_busy[0];
  assign out_busy1      = read_busy[1];
  assign out_busy2      = read_busy[2];

endmodule

// File: doc/register_file_scoreboard.md
# register_file_scoreboard

Parametrised successor to the 16×32 two-read/one-write register file for the single-cycle and upcoming multi-cycle SRC processors. Provides 2^A registers of W bits, three combinational read ports, two write ports with fixed priority, optional same-cycle write-to-read bypass, and a per-register busy scoreboard. The scoreboard lets the control unit stall on operands whose producing instruction has not yet written back.

## Interface
- W, 32, register width in bits
- A, 4, address width; depth = 2^A registers (A ≥ 1)
- clk  input  1  rising-edge clock, single clock domain
- reset_synchronous  input  1  synchronous, active-high reset
- write_enable  input  1  write port 0 enable
- inp_write_address0  input  A  write port 0 address
- inp_write_data  input  W  write port 0 data
- write_enable1  input  1  write port 1 enable
- inp_write_address1  input  A  write port 1 address
- inp_write_data1  input  W  write port 1 data
- inp_read_address0/1/2  input  A  read port addresses
- out_read_data0/1/2  output  W  read port data
- out_busy0/1/2  output  1  scoreboard busy bit for the register addressed by each read port
- reserve_enable  input  1  mark a register busy (pending producer)
- inp_reserve_address  input  A  register to reserve
- out_reserve_conflict  output  1  registered; reserve was issued to an already-busy register
- out_busy_count  output  A+1  registered; number of busy registers

## Operation
- Clock and reset: one clock (clk); reset_synchronous is synchronous and active-high. Reset has priority over every write and reserve in the same cycle.
- Storage: 2^A × W registers and 2^A busy bits.
- Write: on a rising clk edge with write_enable = 1, inp_write_data is stored at inp_write_address0. Port 1 behaves the same way.
- Write collision: if both ports are enabled to the same address, port 1 wins and port 0 is dropped.
- Write clears busy: any enabled write clears the busy bit of its address.
- Reserve: reserve_enable = 1 sets the busy bit of inp_reserve_address.
  - If a write to the same address occurs in the same cycle, reserve wins and the bit ends at 1, because the reserve names a newer producer.
- Conflict: out_reserve_conflict = 1 in the cycle after a reserve whose target bit was already 1 and was not cleared by a write that cycle. Otherwise 0.
- Busy count: out_busy_count equals the popcount of the busy vector as updated on that edge.
  - It saturates naturally at 2^A, which is why it is A+1 bits wide.
- Reads: out_read_dataN and out_busyN are combinational from inp_read_addressN.
  - Any number of ports may read the same address.

## Timing
- Reset values: all registers 0, all busy bits 0, out_reserve_conflict 0, out_busy_count 0. After reset, out_read_dataN = 0 and out_busyN = 0 for any address.
- Write latency: the stored value is visible one cycle after the write edge when bypass is compiled out, and in the same cycle when bypass is compiled in.
- Reset asserted mid-stream: writes and reserves in that cycle are discarded.
- Counter and flag update only on clk edges. No handshake; the block never backpressures.

## Configuration
- REGFILE_BYPASS_EN defined (write-first):
  - A read whose address matches an enabled write in the same cycle returns that write's data, with the port 1 value if both ports match.
  - out_busyN reads 0 for that address, unless a same-cycle reserve also targets it.
- REGFILE_BYPASS_EN undefined (read-before-write):
  - Reads return the stored value.
  - out_busyN reflects the stored busy bit only.

## Test plan
- Reset, then read all addresses on all three ports -> every out_read_dataN = 0, out_busyN = 0, out_busy_count = 0.
- Write 0xDEADBEEF to R3 on port 0 while reading R3 on port 0 -> same cycle: 0xDEADBEEF with bypass, 0 without. Next cycle: 0xDEADBEEF in both builds.
- Both ports write R5 (port 0: 0x11111111, port 1: 0x22222222) -> R5 = 0x22222222 on all read ports.
- Reserve R7, then R9 -> out_busy_count 1 then 2, out_busy for R7 = 1. Reserve R7 again -> out_reserve_conflict = 1 for one cycle, count stays 2. Write R7 -> count 1, busy R7 = 0.
- Write to R2 and reserve R2 in the same cycle -> busy R2 = 1 and R2 holds the new data. Assert reset_synchronous together with a write to R4 -> R4 = 0 and all busy bits 0.
